// File: rtl/cdc_hs_sender_if.sv
// cdc_hs_sender_if: source-side handshake bundle between the sender and its user/receiver
interface cdc_hs_sender_if #(
  parameter int DATA_W = 8,
  parameter int TMO_W  = 8,
  parameter int CNT_W  = 16
);
  logic              start;
  logic [DATA_W-1:0] data_in;
  logic              ack;
  logic [TMO_W-1:0]  timeout_cfg;
  logic              clear_err;
  logic              ready;
  logic              req_out;
  logic [DATA_W-1:0] data_out;
  logic              send_ctrl;
  logic              err_timeout;
  logic [CNT_W-1:0]  xfer_cnt;
  modport master (
    output start, data_in, ack, timeout_cfg, clear_err,
    input  ready, req_out, data_out, send_ctrl, err_timeout, xfer_cnt
  );
  modport slave (
    input  start, data_in, ack, timeout_cfg, clear_err,
    output ready, req_out, data_out, send_ctrl, err_timeout, xfer_cnt
  );
endinterface

// File: rtl/cdc_hs_sender.sv
// cdc_hs_sender: source half of a req/ack CDC handshake with timeout monitor and transfer counter
module cdc_hs_sender #(
  parameter int DATA_W      = 8,
  parameter int MODE_4PH    = 1,
  parameter int SYNC_STAGES = 2,
  parameter int TMO_W       = 8,
  parameter int CNT_W       = 16
) (
  input logic             clk,
  input logic             rst_n,
  cdc_hs_sender_if.slave  hs
);
  typedef enum logic [1:0] {IDLE, REQ1, REQ0, WAIT} state_t;
  localparam bit M4 = (MODE_4PH != 0);
  state_t                 state_q, state_d;
  logic                   req_q, req_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic                   send_q, done;
  logic                   err_q, err_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s, legal;
  assign ack_s = sync_q[SYNC_STAGES-1];
  assign legal = M4 ? (state_q != WAIT) : (state_q == IDLE || state_q == WAIT);
  // Next state, request level, payload capture and completion strobe
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    done    = 1'b0;
    if (!legal) begin
      state_d = IDLE;
      req_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (hs.start) begin
          state_d = M4 ? REQ1 : WAIT;
          req_d   = M4 ? 1'b1 : ~req_q;
          data_d  = hs.data_in;
        end
        REQ1: if (ack_s) begin
          state_d = REQ0;
          req_d   = 1'b0;
          done    = 1'b1;
        end
        REQ0: if (!ack_s) state_d = IDLE;
        WAIT: if (ack_s == req_q) begin
          state_d = IDLE;
          done    = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // Timeout counter restarts on each state change; a new timeout beats a simultaneous clear
  always_comb begin
    tmo_d = (state_d != state_q) ? '0
          : (state_q != IDLE && tmo_q != '1) ? tmo_q + TMO_W'(1) : tmo_q;
    err_d = (hs.timeout_cfg != '0 && tmo_q == hs.timeout_cfg) | (err_q & ~hs.clear_err);
    cnt_d = cnt_q + CNT_W'(done);
  end
  // State, handshake outputs, ack synchroniser and monitors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      send_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      send_q  <= done;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], hs.ack};
    end
  end
  assign hs.ready       = (state_q == IDLE);
  assign hs.req_out     = req_q;
  assign hs.data_out    = data_q;
  assign hs.send_ctrl   = send_q;
  assign hs.err_timeout = err_q;
  assign hs.xfer_cnt    = cnt_q;
endmodule

// File: tb/tb_cdc_hs_sender.sv
// tb_cdc_hs_sender: directed checks of four-phase, two-phase and narrow-counter senders
module tb_cdc_hs_sender;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic echo4 = 1'b1;
  logic ack4_man = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  cdc_hs_sender_if #(.DATA_W(8), .TMO_W(8), .CNT_W(16)) if4();
  cdc_hs_sender_if #(.DATA_W(8), .TMO_W(8), .CNT_W(16)) if2();
  cdc_hs_sender_if #(.DATA_W(8), .TMO_W(8), .CNT_W(2))  ifc();
  cdc_hs_sender #(.DATA_W(8), .MODE_4PH(1), .SYNC_STAGES(2), .TMO_W(8), .CNT_W(16))
    u4 (.clk(clk), .rst_n(rst_n), .hs(if4.slave));
  cdc_hs_sender #(.DATA_W(8), .MODE_4PH(0), .SYNC_STAGES(2), .TMO_W(8), .CNT_W(16))
    u2 (.clk(clk), .rst_n(rst_n), .hs(if2.slave));
  cdc_hs_sender #(.DATA_W(8), .MODE_4PH(1), .SYNC_STAGES(2), .TMO_W(8), .CNT_W(2))
    uc (.clk(clk), .rst_n(rst_n), .hs(ifc.slave));
  // Receiver models: echo req back as ack half a cycle later
  always @(negedge clk) begin
    if4.ack = echo4 ? if4.req_out : ack4_man;
    if2.ack = if2.req_out;
    ifc.ack = ifc.req_out;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  initial begin
    int pulses;
    int exp_c [5] = '{1, 2, 3, 0, 1};
    {if4.start, if4.data_in, if4.timeout_cfg, if4.clear_err} = '0;
    {if2.start, if2.data_in, if2.timeout_cfg, if2.clear_err} = '0;
    {ifc.start, ifc.data_in, ifc.timeout_cfg, ifc.clear_err} = '0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("rst_ready", if4.ready, 1);
    chk("rst_req", if4.req_out, 0);
    chk("rst_data", if4.data_out, 0);
    chk("rst_send", if4.send_ctrl, 0);
    chk("rst_err", if4.err_timeout, 0);
    chk("rst_cnt", if4.xfer_cnt, 0);
    chk("rst_ready2", if2.ready, 1);
    // four-phase single transfer
    if4.start = 1'b1;
    if4.data_in = 8'hA5;
    step();
    if4.start = 1'b0;
    chk("p4_c1_req", if4.req_out, 1);
    chk("p4_c1_data", if4.data_out, 8'hA5);
    chk("p4_c1_ready", if4.ready, 0);
    repeat (3) step();
    chk("p4_c4_send", if4.send_ctrl, 1);
    chk("p4_c4_req", if4.req_out, 0);
    step();
    chk("p4_c5_send", if4.send_ctrl, 0);
    step();
    chk("p4_c6_ready", if4.ready, 0);
    step();
    chk("p4_c7_ready", if4.ready, 1);
    chk("p4_c7_cnt", if4.xfer_cnt, 1);
    // start held every cycle during a transfer
    pulses = 0;
    if4.start = 1'b1;
    if4.data_in = 8'h5A;
    for (int i = 1; i <= 6; i++) begin
      step();
      pulses += int'(if4.send_ctrl);
      chk("flood_data", if4.data_out, 8'h5A);
      if4.data_in = 8'(8'hC0 + i);
    end
    step();
    if4.start = 1'b0;
    pulses += int'(if4.send_ctrl);
    chk("flood_ready", if4.ready, 1);
    chk("flood_data_end", if4.data_out, 8'h5A);
    chk("flood_cnt", if4.xfer_cnt, 2);
    chk("flood_pulses", pulses, 1);
    // timeout with ack withheld; clear held across the setting edge
    echo4 = 1'b0;
    ack4_man = 1'b0;
    if4.timeout_cfg = 8'd5;
    if4.clear_err = 1'b1;
    if4.start = 1'b1;
    if4.data_in = 8'h77;
    step();
    if4.start = 1'b0;
    repeat (4) step();
    chk("tmo_c5_err", if4.err_timeout, 0);
    repeat (2) step();
    if4.clear_err = 1'b0;
    chk("tmo_set_wins", if4.err_timeout, 1);
    chk("tmo_req_held", if4.req_out, 1);
    ack4_man = 1'b1;
    for (int i = 0; i < 12 && !if4.send_ctrl; i++) step();
    chk("tmo_late_send", if4.send_ctrl, 1);
    ack4_man = 1'b0;
    for (int i = 0; i < 12 && !if4.ready; i++) step();
    chk("tmo_late_ready", if4.ready, 1);
    chk("tmo_sticky", if4.err_timeout, 1);
    chk("tmo_cnt", if4.xfer_cnt, 3);
    if4.clear_err = 1'b1;
    step();
    if4.clear_err = 1'b0;
    chk("tmo_clear", if4.err_timeout, 0);
    // monitor disabled
    if4.timeout_cfg = 8'd0;
    if4.start = 1'b1;
    if4.data_in = 8'h99;
    step();
    if4.start = 1'b0;
    repeat (20) step();
    chk("tmo_off_err", if4.err_timeout, 0);
    chk("tmo_off_req", if4.req_out, 1);
    ack4_man = 1'b1;
    for (int i = 0; i < 12 && !if4.send_ctrl; i++) step();
    chk("tmo_off_send", if4.send_ctrl, 1);
    ack4_man = 1'b0;
    for (int i = 0; i < 12 && !if4.ready; i++) step();
    chk("tmo_off_ready", if4.ready, 1);
    echo4 = 1'b1;
    // two-phase back-to-back
    if2.start = 1'b1;
    if2.data_in = 8'h11;
    step();
    if2.start = 1'b0;
    chk("p2_req_1", if2.req_out, 1);
    chk("p2_data_1", if2.data_out, 8'h11);
    repeat (3) step();
    chk("p2_send_1", if2.send_ctrl, 1);
    chk("p2_ready_1", if2.ready, 1);
    if2.start = 1'b1;
    if2.data_in = 8'h22;
    step();
    if2.start = 1'b0;
    chk("p2_req_0", if2.req_out, 0);
    chk("p2_data_2", if2.data_out, 8'h22);
    chk("p2_send_gap", if2.send_ctrl, 0);
    repeat (3) step();
    chk("p2_send_2", if2.send_ctrl, 1);
    step();
    chk("p2_send_end", if2.send_ctrl, 0);
    chk("p2_cnt", if2.xfer_cnt, 2);
    chk("p2_req_level", if2.req_out, 0);
    // narrow counter wrap
    for (int k = 0; k < 5; k++) begin
      ifc.start = 1'b1;
      ifc.data_in = 8'(k);
      step();
      ifc.start = 1'b0;
      repeat (6) step();
      chk("cnt_wrap_ready", ifc.ready, 1);
      chk("cnt_wrap_val", ifc.xfer_cnt, exp_c[k]);
    end
    // asynchronous reset while in REQ0 with the error flag set
    if4.timeout_cfg = 8'd1;
    if4.start = 1'b1;
    if4.data_in = 8'hEE;
    step();
    if4.start = 1'b0;
    for (int i = 0; i < 12 && !if4.send_ctrl; i++) step();
    chk("mid_send", if4.send_ctrl, 1);
    chk("mid_err_pre", if4.err_timeout, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_req", if4.req_out, 0);
    chk("mid_ready", if4.ready, 1);
    chk("mid_cnt", if4.xfer_cnt, 0);
    chk("mid_err", if4.err_timeout, 0);
    chk("mid_data", if4.data_out, 0);
    if4.timeout_cfg = 8'd0;
    step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("post_rst_ready", if4.ready, 1);
    chk("post_rst_req", if4.req_out, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
